// File: rtl/stream_zip_pkg.sv
// Shared state type, token helpers and the sum-reduction function for stream_zip_add.
// Defining STREAM_ZIP_SATURATE_EN makes reduce_sum saturate instead of wrapping.
package stream_zip_pkg;

    localparam int N_DEF = 2;
    localparam int W_DEF = 32;
    localparam int SUM_W = W_DEF + $clog2(N_DEF);

    // The helpers take operands zero-extended to these bounds so one body serves every N/W.
    localparam int MAX_W     = 64;
    localparam int MAX_TOK_W = MAX_W + 1;
    localparam int MAX_SUM_W = MAX_W + 3;
    localparam int IDX_W     = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic token_eot(input logic [MAX_TOK_W-1:0] tok,
                                       input logic [IDX_W-1:0]     w);
        return tok[w];
    endfunction

    function automatic logic [MAX_W-1:0] reduce_sum(input logic [MAX_SUM_W-1:0] sum,
                                                    input logic [IDX_W-1:0]     w);
        logic [MAX_W-1:0] res;
`ifdef STREAM_ZIP_SATURATE_EN
        logic ovf;
        ovf = 1'b0;
        for (int i = 0; i < MAX_SUM_W; i++) begin
            if (i >= int'(w) && sum[i]) begin
                ovf = 1'b1;
            end
        end
`endif
        res = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < int'(w)) begin
`ifdef STREAM_ZIP_SATURATE_EN
                res[i] = sum[i] | ovf;
`else
                res[i] = sum[i];
`endif
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/stream_zip_out_slot.sv
// Single-entry output register for a FIFO-style write port: holds one token,
// pushes it when the consumer has space, and accepts a new token in the same cycle.
module stream_zip_out_slot
    import stream_zip_pkg::*;
#(
    parameter int TOK_W = 33
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             load,
    input  logic [TOK_W-1:0] load_tok,
    input  logic             full_n,
    output logic             can_load,
    output logic             write,
    output logic [TOK_W-1:0] dout
);

    logic             valid_q, valid_d;
    logic [TOK_W-1:0] tok_q, tok_d;

    assign write    = valid_q & full_n;
    assign can_load = ~valid_q | full_n;
    assign dout     = tok_q;

    // The token register is cleared on every drain so an empty slot always presents zero.
    always_comb begin
        valid_d = valid_q;
        tok_d   = tok_q;
        if (write) begin
            valid_d = 1'b0;
            tok_d   = '0;
        end
        if (load) begin
            valid_d = 1'b1;
            tok_d   = load_tok;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            valid_q <= 1'b0;
            tok_q   <= '0;
        end else begin
            valid_q <= valid_d;
            tok_q   <= tok_d;
        end
    end

endmodule

// File: rtl/stream_zip_add.sv
// N-channel lock-step stream adder with ap_ctrl_hs control and close-token alignment check.
// Build option: STREAM_ZIP_SATURATE_EN (saturating sums, see stream_zip_pkg).
module stream_zip_add
    import stream_zip_pkg::*;
#(
    parameter int N = 2,
    parameter int W = 32
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    input  logic                 ap_start,
    output logic                 ap_done,
    output logic                 ap_idle,
    output logic                 ap_ready,
    input  logic [N*(W+1)-1:0]   in_s_dout,
    input  logic [N-1:0]         in_s_empty_n,
    output logic [N-1:0]         in_s_read,
    output logic [W:0]           out_s_din,
    input  logic                 out_s_full_n,
    output logic                 out_s_write,
    output logic                 err_mismatch
);

    localparam int TOK_W = W + 1;
    localparam int ACC_W = W + $clog2(N);

    logic [W:0]       chan_tok  [N];
    logic [W-1:0]     chan_data [N];
    logic [N-1:0]     chan_eot;

    logic [ACC_W-1:0] sum_full;
    logic [W-1:0]     sum_data;

    state_e           state_q, state_d;
    logic             err_q, err_d;
    logic             eot_pend_q, eot_pend_d;
    logic [31:0]      elem_count_q, elem_count_d;
    logic             fire;

    logic             slot_load, slot_can_load, slot_write;
    logic [W:0]       slot_tok, slot_dout;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_chan
            assign chan_tok[gi]  = in_s_dout[gi*TOK_W +: TOK_W];
            assign chan_data[gi] = chan_tok[gi][W-1:0];
            assign chan_eot[gi]  = token_eot(MAX_TOK_W'(chan_tok[gi]), IDX_W'(W));
        end
    endgenerate

    always_comb begin
        sum_full = '0;
        for (int k = 0; k < N; k++) begin
            sum_full = sum_full + ACC_W'(chan_data[k]);
        end
    end

    assign sum_data = W'(reduce_sum(MAX_SUM_W'(sum_full), IDX_W'(W)));

    always_comb begin
        state_d      = state_q;
        err_d        = err_q;
        eot_pend_d   = eot_pend_q;
        elem_count_d = elem_count_q;
        in_s_read    = '0;
        slot_load    = 1'b0;
        slot_tok     = '0;
        // Once the close token is queued nothing more is popped: the next transfer's tokens may already be waiting.
        fire = (state_q == RUN) && !eot_pend_q && (&in_s_empty_n) && slot_can_load;

        case (state_q)
            IDLE: begin
                if (ap_start) begin
                    state_d      = RUN;
                    err_d        = 1'b0;
                    eot_pend_d   = 1'b0;
                    elem_count_d = '0;
                end
            end
            RUN: begin
                if (fire) begin
                    if (chan_eot == '0) begin
                        in_s_read    = '1;
                        slot_load    = 1'b1;
                        slot_tok     = {1'b0, sum_data};
                        elem_count_d = elem_count_q + 32'd1;
                    end else if (&chan_eot) begin
                        in_s_read  = '1;
                        slot_load  = 1'b1;
                        slot_tok   = {1'b1, {W{1'b0}}};
                        eot_pend_d = 1'b1;
                    end else begin
                        // Drain the short-of-close channels; closed ones wait for the rest to catch up.
                        in_s_read = ~chan_eot;
                        err_d     = 1'b1;
                    end
                end
                if (slot_write && slot_dout[W]) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (ap_start) begin
                    state_d      = RUN;
                    err_d        = 1'b0;
                    eot_pend_d   = 1'b0;
                    elem_count_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q      <= IDLE;
            err_q        <= 1'b0;
            eot_pend_q   <= 1'b0;
            elem_count_q <= '0;
        end else begin
            state_q      <= state_d;
            err_q        <= err_d;
            eot_pend_q   <= eot_pend_d;
            elem_count_q <= elem_count_d;
        end
    end

    stream_zip_out_slot #(
        .TOK_W(TOK_W)
    ) u_out_slot (
        .clk      (ap_clk),
        .srst     (ap_rst),
        .load     (slot_load),
        .load_tok (slot_tok),
        .full_n   (out_s_full_n),
        .can_load (slot_can_load),
        .write    (slot_write),
        .dout     (slot_dout)
    );

    assign out_s_write  = slot_write;
    assign out_s_din    = slot_dout;
    assign err_mismatch = err_q;
    assign ap_idle      = (state_q == IDLE);
    assign ap_done      = (state_q == DONE);
    assign ap_ready     = (state_q == DONE);

endmodule

// File: tb/tb_stream_zip_add.sv
// Directed bench for stream_zip_add: one N=2/W=32 instance and one N=4/W=8 instance
// fed from per-channel FIFO models; every result is compared against hand-computed values.
module tb_stream_zip_add;

    localparam int NA = 2;
    localparam int WA = 32;
    localparam int TA = WA + 1;
    localparam int NB = 4;
    localparam int WB = 8;
    localparam int TB = WB + 1;

    localparam logic [TA-1:0] EOT_A = {1'b1, 32'd0};
    localparam logic [TB-1:0] EOT_B = 9'h100;
`ifdef STREAM_ZIP_SATURATE_EN
    localparam logic [63:0] EXP_OVF = 64'd255;
`else
    localparam logic [63:0] EXP_OVF = 64'd44;
`endif

    logic clk = 1'b0;
    logic rst;

    logic             start_a, done_a, idle_a, ready_a, full_n_a, write_a, err_a;
    logic [NA*TA-1:0] dout_a;
    logic [NA-1:0]    empty_n_a, read_a;
    logic [TA-1:0]    din_a;

    logic             start_b, done_b, idle_b, ready_b, full_n_b, write_b, err_b;
    logic [NB*TB-1:0] dout_b;
    logic [NB-1:0]    empty_n_b, read_b;
    logic [TB-1:0]    din_b;

    logic [TA-1:0] src_a [NA][16];
    int            len_a [NA];
    int            rd_a  [NA];
    logic [NA-1:0] gate_a;
    logic [TB-1:0] src_b [NB][16];
    int            len_b [NB];
    int            rd_b  [NB];
    logic [NB-1:0] gate_b;

    logic [TA-1:0] got_a [$];
    logic [TB-1:0] got_b [$];
    int            wcyc_a [$];
    int            first_rd_a;
    logic [NB-1:0] last_read_b;
    logic          bp_en;
    logic [3:0]    bp_pat = 4'b1001;   // full_n sequence 1,0,0,1 indexed by cycle mod 4
    int            cyc, viol, done_cnt_a, done_cnt_b;
    int            checks, errors;

    always #5 clk = ~clk;

    stream_zip_add #(.N(NA), .W(WA)) u_dut_a (
        .ap_clk       (clk),
        .ap_rst       (rst),
        .ap_start     (start_a),
        .ap_done      (done_a),
        .ap_idle      (idle_a),
        .ap_ready     (ready_a),
        .in_s_dout    (dout_a),
        .in_s_empty_n (empty_n_a),
        .in_s_read    (read_a),
        .out_s_din    (din_a),
        .out_s_full_n (full_n_a),
        .out_s_write  (write_a),
        .err_mismatch (err_a)
    );

    stream_zip_add #(.N(NB), .W(WB)) u_dut_b (
        .ap_clk       (clk),
        .ap_rst       (rst),
        .ap_start     (start_b),
        .ap_done      (done_b),
        .ap_idle      (idle_b),
        .ap_ready     (ready_b),
        .in_s_dout    (dout_b),
        .in_s_empty_n (empty_n_b),
        .in_s_read    (read_b),
        .out_s_din    (din_b),
        .out_s_full_n (full_n_b),
        .out_s_write  (write_b),
        .err_mismatch (err_b)
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic push_a(input int ch, input logic [TA-1:0] tok);
        src_a[ch][len_a[ch]] = tok;
        len_a[ch]++;
    endtask

    task automatic push_b(input int ch, input logic [TB-1:0] tok);
        src_b[ch][len_b[ch]] = tok;
        len_b[ch]++;
    endtask

    task automatic clear_src();
        for (int ch = 0; ch < NA; ch++) begin
            len_a[ch] = 0;
            rd_a[ch]  = 0;
        end
        for (int ch = 0; ch < NB; ch++) begin
            len_b[ch] = 0;
            rd_b[ch]  = 0;
        end
        gate_a     = '1;
        gate_b     = '1;
        first_rd_a = -1;
        got_a.delete();
        got_b.delete();
        wcyc_a.delete();
    endtask

    // One clock: present FIFO heads, observe at the falling edge, pop what was read, return after the rising edge.
    task automatic tick();
        for (int ch = 0; ch < NA; ch++) begin
            empty_n_a[ch]        = gate_a[ch] && (rd_a[ch] < len_a[ch]);
            dout_a[ch*TA +: TA]  = (rd_a[ch] < len_a[ch]) ? src_a[ch][rd_a[ch]] : '0;
        end
        for (int ch = 0; ch < NB; ch++) begin
            empty_n_b[ch]        = gate_b[ch] && (rd_b[ch] < len_b[ch]);
            dout_b[ch*TB +: TB]  = (rd_b[ch] < len_b[ch]) ? src_b[ch][rd_b[ch]] : '0;
        end
        full_n_b = bp_en ? bp_pat[cyc % 4] : 1'b1;
        @(negedge clk);
        if ((read_a & ~empty_n_a) != '0 || (write_a && !full_n_a) || done_a != ready_a) viol++;
        if ((read_b & ~empty_n_b) != '0 || (write_b && !full_n_b) || done_b != ready_b) viol++;
        last_read_b = read_b;
        if (read_a != '0 && first_rd_a < 0) first_rd_a = cyc;
        if (write_a) begin
            got_a.push_back(din_a);
            wcyc_a.push_back(cyc);
            $display("[%0d] a write %h", cyc, din_a);
        end
        if (write_b) begin
            got_b.push_back(din_b);
            $display("[%0d] b write %h", cyc, din_b);
        end
        if (done_a) done_cnt_a++;
        if (done_b) done_cnt_b++;
        for (int ch = 0; ch < NA; ch++) if (read_a[ch]) rd_a[ch]++;
        for (int ch = 0; ch < NB; ch++) if (read_b[ch]) rd_b[ch]++;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic kick(input bit use_b);
        if (use_b) start_b = 1'b1;
        else       start_a = 1'b1;
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_done(input bit use_b, input string tag);
        int base;
        int n;
        base = use_b ? done_cnt_b : done_cnt_a;
        n = 0;
        while ((use_b ? done_cnt_b : done_cnt_a) == base && n < 200) begin
            tick();
            n++;
        end
        repeat (3) tick();
        check_eq(tag, 64'(use_b ? done_cnt_b - base : done_cnt_a - base), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; errors = 0; cyc = 0; viol = 0; done_cnt_a = 0; done_cnt_b = 0;
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; full_n_a = 1'b1; bp_en = 1'b0;
        clear_src();
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check_eq("rst_idle_a", 64'(idle_a), 64'd1);
        check_eq("rst_done_a", 64'(done_a), 64'd0);
        check_eq("rst_ready_a", 64'(ready_a), 64'd0);
        check_eq("rst_read_a", 64'(read_a), 64'd0);
        check_eq("rst_write_a", 64'(write_a), 64'd0);
        check_eq("rst_din_a", 64'(din_a), 64'd0);
        check_eq("rst_err_a", 64'(err_a), 64'd0);
        check_eq("rst_idle_b", 64'(idle_b), 64'd1);

        // Basic: a = 0..4, b = 1..5
        clear_src();
        for (int i = 0; i < 5; i++) begin
            push_a(0, TA'(i));
            push_a(1, TA'(i + 1));
        end
        push_a(0, EOT_A);
        push_a(1, EOT_A);
        kick(1'b0);
        wait_done(1'b0, "t1_done_once");
        check_eq("t1_count", 64'(got_a.size()), 64'd6);
        for (int i = 0; i < 5; i++) check_eq($sformatf("t1_out%0d", i), 64'(got_a[i]), 64'(2 * i + 1));
        check_eq("t1_eot", 64'(got_a[5]), 64'(EOT_A));
        check_eq("t1_err", 64'(err_a), 64'd0);
        check_eq("t1_latency", 64'(wcyc_a[0] - first_rd_a), 64'd1);
        check_eq("t1_back_to_back", 64'(wcyc_a[5] - wcyc_a[0]), 64'd5);
        check_eq("t1_idle", 64'(idle_a), 64'd1);
        check_eq("t1_protocol", 64'(viol), 64'd0);

        // Backpressure, N=4: 10+20+30+40 three times, full_n 1,0,0,1
        clear_src();
        for (int k = 0; k < NB; k++) begin
            for (int i = 0; i < 3; i++) push_b(k, TB'(10 * (k + 1)));
            push_b(k, EOT_B);
        end
        bp_en = 1'b1;
        kick(1'b1);
        wait_done(1'b1, "t2_done_once");
        bp_en = 1'b0;
        check_eq("t2_count", 64'(got_b.size()), 64'd4);
        for (int i = 0; i < 3; i++) check_eq($sformatf("t2_out%0d", i), 64'(got_b[i]), 64'd100);
        check_eq("t2_eot", 64'(got_b[3]), 64'(EOT_B));
        check_eq("t2_consumed", 64'(rd_b[0] + rd_b[1] + rd_b[2] + rd_b[3]), 64'd16);
        check_eq("t2_protocol", 64'(viol), 64'd0);

        // Skewed availability: channel 2 withheld for 5 cycles
        clear_src();
        for (int k = 0; k < NB; k++) begin
            for (int i = 0; i < 3; i++) push_b(k, TB'(k + 1));
            push_b(k, EOT_B);
        end
        gate_b = 4'b1011;
        kick(1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq($sformatf("t3_hold%0d", i), 64'(last_read_b), 64'd0);
        end
        gate_b = 4'b1111;
        tick();
        check_eq("t3_release", 64'(last_read_b), 64'hF);
        wait_done(1'b1, "t3_done_once");
        check_eq("t3_count", 64'(got_b.size()), 64'd4);
        check_eq("t3_out0", 64'(got_b[0]), 64'd10);

        // Misaligned close: a = 1,2,EoT ; b = 5,EoT
        clear_src();
        push_a(0, TA'(1));
        push_a(0, TA'(2));
        push_a(0, EOT_A);
        push_a(1, TA'(5));
        push_a(1, EOT_A);
        kick(1'b0);
        wait_done(1'b0, "t4_done_once");
        check_eq("t4_count", 64'(got_a.size()), 64'd2);
        check_eq("t4_out0", 64'(got_a[0]), 64'd6);
        check_eq("t4_eot", 64'(got_a[1]), 64'(EOT_A));
        check_eq("t4_err", 64'(err_a), 64'd1);
        check_eq("t4_rd_a", 64'(rd_a[0]), 64'd3);
        check_eq("t4_rd_b", 64'(rd_a[1]), 64'd2);

        // Overflow at W=8: 200 + 100 + 0 + 0
        clear_src();
        push_b(0, TB'(200));
        push_b(1, TB'(100));
        push_b(2, TB'(0));
        push_b(3, TB'(0));
        for (int k = 0; k < NB; k++) push_b(k, EOT_B);
        kick(1'b1);
        wait_done(1'b1, "t5_done_once");
        check_eq("t5_overflow", 64'(got_b[0]), EXP_OVF);

        // Reset mid-run with the output slot holding element 1
        clear_src();
        for (int i = 0; i < 5; i++) begin
            push_a(0, TA'(10 + i));
            push_a(1, TA'(20 + i));
        end
        push_a(0, EOT_A);
        push_a(1, EOT_A);
        full_n_a = 1'b0;
        kick(1'b0);
        tick();
        tick();
        full_n_a = 1'b1;
        tick();
        full_n_a = 1'b0;
        tick();
        check_eq("t6_rd", 64'(rd_a[0]), 64'd2);
        check_eq("t6_held", 64'(din_a), 64'd32);
        full_n_a = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("t6_write", 64'(write_a), 64'd0);
        check_eq("t6_idle", 64'(idle_a), 64'd1);
        check_eq("t6_err", 64'(err_a), 64'd0);
        check_eq("t6_din", 64'(din_a), 64'd0);
        clear_src();
        push_a(0, TA'(3));
        push_a(0, TA'(4));
        push_a(0, EOT_A);
        push_a(1, TA'(5));
        push_a(1, TA'(6));
        push_a(1, EOT_A);
        kick(1'b0);
        wait_done(1'b0, "t6_done_once");
        check_eq("t6_count", 64'(got_a.size()), 64'd3);
        check_eq("t6_out0", 64'(got_a[0]), 64'd8);
        check_eq("t6_out1", 64'(got_a[1]), 64'd10);
        check_eq("t6_eot", 64'(got_a[2]), 64'(EOT_A));
        check_eq("final_protocol", 64'(viol), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
